ram_fifo_ctrl: RTL
==================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; depth = 2**ADDR_W = 256 entries.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_valid  input  1  producer offers wr_data.
REQ-006 wr_ready  output  1  block accepts; push occurs when wr_valid && wr_ready.
REQ-007 wr_data  input  DATA_W  push data.
REQ-008 rd_valid  output  1  rd_data holds head entry.
REQ-009 rd_ready  input  1  consumer accepts; pop occurs when rd_valid && rd_ready.
REQ-010 rd_data  output  DATA_W  head entry.
REQ-011 addr1  output  ADDR_W  RAM write-port address.
REQ-012 data_in1  output  DATA_W  RAM write-port data.
REQ-013 write_en1  output  1  RAM write strobe.
REQ-014 addr2  output  ADDR_W  RAM read-port address.
REQ-015 write_en2  output  1  RAM port-2 write strobe, tied 0.
REQ-016 data_in2  output  DATA_W  tied 0.
REQ-017 data_out2  input  DATA_W  RAM read data, valid one cycle after addr2 presented.
REQ-018 count  output  ADDR_W+1  total occupancy (RAM + in-flight + output buffer), 0..256.
REQ-019 full / empty  output  1 each  count==256 / count==0.

Function
REQ-020 wr_ready SHALL equal !full, combinationally.
REQ-021 On push, addr1=wr_ptr, data_in1=wr_data, write_en1=1 in the same cycle (combinational); write_en1 SHALL be 0 otherwise; wr_ptr increments mod 256 on push.
REQ-022 mem_cnt (entries written, not yet fetched) SHALL increment on push, decrement on fetch; both same cycle leaves it unchanged.
REQ-023 A fetch SHALL issue when mem_cnt>0 and (buf_cnt + inflight - pop) < 2; fetch drives addr2=rd_ptr, sets inflight next cycle, increments rd_ptr mod 256.
REQ-024 addr2 SHALL equal rd_ptr whenever no fetch issues.
REQ-025 When inflight=1, data_out2 SHALL be captured into the 2-entry output buffer (FIFO order) that cycle.
REQ-026 rd_valid SHALL equal buf_cnt>0; rd_data SHALL be buffer head.
REQ-027 Sustained push and pop SHALL reach one entry per cycle; first-word latency from push to rd_valid SHALL be 3 cycles (write, fetch, capture).
REQ-028 A fetch SHALL never target an address written in the same cycle (guaranteed by REQ-022 counting only committed writes).
REQ-029 count SHALL increment on push, decrement on pop, unchanged when both; push while full and pop while empty cannot occur.
REQ-030 Pointer wrap 255->0 SHALL be seamless; ordering preserved across wrap.
REQ-031 Push while full (wr_valid=1, count=256) SHALL be ignored, no RAM write; simultaneous pop frees space only for the next cycle.

Reset
REQ-032 rst=1 SHALL immediately clear wr_ptr, rd_ptr, mem_cnt, inflight, buf_cnt, count; rd_valid=0, empty=1, full=0, wr_ready=1, write_en1=0 while rst asserted.
REQ-033 Reset mid-operation SHALL discard all contents and any in-flight read; RAM contents are not cleared.

Structure
REQ-034 ADDR_W, DATA_W defaults and depth constant SHALL live in shared package ram_fifo_pkg.
REQ-035 The 2-entry output buffer SHALL be sub-module fifo_out_buf (push/pop/count, DATA_W wide).

Verification
REQ-036 Reset, then push 0x11,0x22,0x33 back-to-back with rd_ready=0 -> rd_valid rises 3 cycles after first push, rd_data=0x11, count=3.
REQ-037 256 pushes with rd_ready=0 -> full=1, wr_ready=0, count=256; 257th push ignored, write_en1 stays 0.
REQ-038 Continuous push 0x00..0xFF and rd_ready=1 -> after first-word latency, one pop per cycle, data in order, count constant.
REQ-039 Push/pop 300 entries -> pointers wrap; entry 257 reads back correctly at addr 0x00.
REQ-040 rd_ready toggling 1/0 each cycle during streaming -> no loss/duplication, buffer never exceeds 2.
REQ-041 Assert rst asynchronously mid-stream with inflight=1 -> outputs clear immediately; next pushed 0xAB is first read.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared sizing constants for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

    // Occupancy width of the small output skid buffer (0..2 entries).
    localparam int unsigned BUF_CNT_W  = 2;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer, consumer and dual-port RAM signals of the FIFO controller.
interface ram_fifo_ctrl_if
    import ram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data_in1;
    logic              write_en1;
    logic [ADDR_W-1:0] addr2;
    logic              write_en2;
    logic [DATA_W-1:0] data_in2;
    logic [DATA_W-1:0] data_out2;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;

    // Controller side.
    modport slave (
        input  wr_valid, wr_data, rd_ready, data_out2,
        output wr_ready, rd_valid, rd_data, addr1, data_in1, write_en1,
               addr2, write_en2, data_in2, count, full, empty
    );

    // Producer / consumer / RAM side.
    modport master (
        output wr_valid, wr_data, rd_ready, data_out2,
        input  wr_ready, rd_valid, rd_data, addr1, data_in1, write_en1,
               addr2, write_en2, data_in2, count, full, empty
    );

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry FIFO that holds words fetched from the RAM until consumed.
module fifo_out_buf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [DATA_W-1:0]    i_data,
    output logic [DATA_W-1:0]    o_data,
    output logic [BUF_CNT_W-1:0] o_cnt
);

    logic [DATA_W-1:0]    r_mem [2];
    logic                 r_head;
    logic [BUF_CNT_W-1:0] r_cnt;
    logic                 w_tail;

    // The controller never pushes into a full buffer, so tail = head + cnt mod 2.
    assign w_tail = r_head ^ r_cnt[0];

    // Storage: data needs no reset, occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_tail] <= i_data;
        end
    end

    // Head pointer and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + BUF_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - BUF_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_data = r_mem[r_head];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller storing entries in an external dual-port RAM, with a
// two-entry output buffer hiding the one-cycle RAM read latency.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    ram_fifo_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_W);

    logic [ADDR_W-1:0]    r_wr_ptr;
    logic [ADDR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]     r_mem_cnt;
    logic [CNT_W-1:0]     r_count;
    logic                 r_inflight;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fetch;
    logic [2:0]           w_occ_after;
    logic [BUF_CNT_W-1:0] w_buf_cnt;
    logic [DATA_W-1:0]    w_buf_data;

    assign w_full = (r_count == DEPTH_C);
    // Gated by rst so no RAM write can escape while reset is held.
    assign w_push = bus.wr_valid && !w_full && !rst;
    assign w_pop  = (w_buf_cnt != '0) && bus.rd_ready;

    // Fetch only if the word will still fit once it lands next cycle.
    assign w_occ_after = 3'(w_buf_cnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_fetch     = (r_mem_cnt != '0) && (w_occ_after < 3'd2);

    assign bus.wr_ready  = !w_full;
    assign bus.addr1     = r_wr_ptr;
    assign bus.data_in1  = bus.wr_data;
    assign bus.write_en1 = w_push;
    assign bus.addr2     = r_rd_ptr;
    assign bus.write_en2 = 1'b0;
    assign bus.data_in2  = '0;
    assign bus.rd_valid  = (w_buf_cnt != '0);
    assign bus.rd_data   = w_buf_data;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = (r_count == '0);

    // RAM pointers, committed-entry count and read-in-flight flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_fetch) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_fetch})
                2'b10:   r_mem_cnt <= r_mem_cnt + CNT_W'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CNT_W'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            r_inflight <= w_fetch;
        end
    end

    // Total occupancy seen by producer and consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_out_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_data (bus.data_out2),
        .o_data (w_buf_data),
        .o_cnt  (w_buf_cnt)
    );

endmodule
